// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache.
// Covers the word and address widths, the controller states, and the helpers
// that split a word address into tag / index / offset fields.
package cache_pkg;

  localparam int WORD_W        = 16;
  localparam int ADDR_W        = 16;
  localparam int DEFAULT_LINES = 4;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_e;

  // Index field width for a power-of-two number of lines
  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Offset field width for a power-of-two number of words per line
  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

  // Tag field takes every address bit above index and offset
  function automatic int tag_width(input int lines, input int words);
    return ADDR_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Storage for the direct-mapped cache: per-line valid bit, tag and data words.
// The read port is purely combinational so read hits can complete in the
// request cycle. Line fills and single-word store updates share one write process.
module cache_line_array
  import cache_pkg::*;
#(
  parameter  int LINES = DEFAULT_LINES,
  parameter  int WORDS = DEFAULT_WORDS,
  localparam int IDX_W = idx_width(LINES),
  localparam int OFF_W = off_width(WORDS),
  localparam int TAG_W = tag_width(LINES, WORDS)
) (
  input  logic                    Clk,
  input  logic                    Reset_N,
  input  logic [IDX_W-1:0]        rd_index,
  input  logic [OFF_W-1:0]        rd_offset,
  output logic                    rd_valid,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [WORD_W-1:0]       rd_word,
  input  logic                    fill_en,
  input  logic [IDX_W-1:0]        fill_index,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [WORD_W*WORDS-1:0] fill_line,
  input  logic                    word_en,
  input  logic [IDX_W-1:0]        word_index,
  input  logic [OFF_W-1:0]        word_offset,
  input  logic [WORD_W-1:0]       word_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES][WORDS];

  // Valid bits are the only state cleared by reset; a completed fill marks its line present
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag/data storage: a fill rewrites the whole line, a store hit patches a single word
  always_ff @(posedge Clk) begin
    if (fill_en) begin
      tag_q[fill_index] <= fill_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_q[fill_index][w] <= fill_line[w*WORD_W +: WORD_W];
      end
    end else if (word_en) begin
      data_q[word_index][word_offset] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// It sits between the pipeline MEM stage and a multi-cycle data memory.
// Read hits return data in the request cycle. Read misses fetch a whole line,
// and every store goes through to memory. The pipeline is stalled until the
// memory acknowledges. Saturating read hit/miss counters are kept for test programs.
module data_cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                    Clk,
  input  logic                    Reset_N,
  input  logic                    d_readM,
  input  logic                    d_writeM,
  input  logic [ADDR_W-1:0]       d_address,
  input  logic [WORD_W-1:0]       d_wdata,
  output logic [WORD_W-1:0]       d_rdata,
  output logic                    d_stall,
  output logic                    m_readM,
  output logic                    m_writeM,
  output logic [ADDR_W-1:0]       m_address,
  output logic [WORD_W-1:0]       m_wdata,
  input  logic [WORD_W*WORDS-1:0] m_rdata,
  input  logic                    m_ack,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam int          IDX_W     = idx_width(LINES);
  localparam int          OFF_W     = off_width(WORDS);
  localparam int          TAG_W     = tag_width(LINES, WORDS);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  cache_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_index;
  logic [OFF_W-1:0]  rd_offset;
  logic [TAG_W-1:0]  rd_tag_field;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_word;
  logic              hit;
  logic [WORD_W-1:0] fill_word;
  logic              start_fill;
  logic              start_write;
  logic              fill_en;
  logic              word_en;
  logic              count_hit;
  logic              count_miss;

  // In WRITE the lookup must use the latched store address, otherwise the live request
  assign rd_addr      = (state_q == WRITE) ? req_addr_q : d_address;
  assign rd_offset    = rd_addr[OFF_W-1:0];
  assign rd_index     = rd_addr[OFF_W +: IDX_W];
  assign rd_tag_field = rd_addr[ADDR_W-1 -: TAG_W];
  assign hit          = rd_valid && (rd_tag == rd_tag_field);

  cache_line_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_lines (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .rd_index    (rd_index),
    .rd_offset   (rd_offset),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word     (rd_word),
    .fill_en     (fill_en),
    .fill_index  (req_addr_q[OFF_W +: IDX_W]),
    .fill_tag    (req_addr_q[ADDR_W-1 -: TAG_W]),
    .fill_line   (m_rdata),
    .word_en     (word_en),
    .word_index  (req_addr_q[OFF_W +: IDX_W]),
    .word_offset (req_addr_q[OFF_W-1:0]),
    .word_data   (m_wdata)
  );

  // Pick the requested word out of the incoming line so a miss can bypass it to the pipeline
  always_comb begin
    fill_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (req_addr_q[OFF_W-1:0] == OFF_W'(w)) begin
        fill_word = m_rdata[w*WORD_W +: WORD_W];
      end
    end
  end

  // Controller state register; reset abandons any access in flight
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pipeline stall/data and one-cycle strobes for the array and counters
  always_comb begin
    state_d     = state_q;
    d_stall     = 1'b0;
    d_rdata     = '0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    count_hit   = 1'b0;
    count_miss  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_writeM) begin
          state_d     = WRITE;
          d_stall     = 1'b1;
          start_write = 1'b1;
        end else if (d_readM) begin
          if (hit) begin
            d_rdata   = rd_word;
            count_hit = 1'b1;
          end else begin
            state_d    = FILL;
            d_stall    = 1'b1;
            start_fill = 1'b1;
            count_miss = 1'b1;
          end
        end
      end
      FILL: begin
        if (m_ack) begin
          d_rdata = fill_word;
          fill_en = 1'b1;
          state_d = IDLE;
        end else begin
          d_stall = 1'b1;
        end
      end
      WRITE: begin
        if (m_ack) begin
          word_en = hit;
          state_d = IDLE;
        end else begin
          d_stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side request registers: loaded on entry to FILL/WRITE, strobes dropped on the ack
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      m_readM    <= 1'b0;
      m_writeM   <= 1'b0;
      m_address  <= '0;
      m_wdata    <= '0;
      req_addr_q <= '0;
    end else if (start_write) begin
      m_writeM   <= 1'b1;
      m_address  <= d_address;
      m_wdata    <= d_wdata;
      req_addr_q <= d_address;
    end else if (start_fill) begin
      m_readM    <= 1'b1;
      m_address  <= {d_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      req_addr_q <= d_address;
    end else if ((state_q != IDLE) && m_ack) begin
      m_readM  <= 1'b0;
      m_writeM <= 1'b0;
    end
  end

  // Saturating load hit/miss counters; stores are not counted
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (count_hit && (hit_count != COUNT_MAX)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (count_miss && (miss_count != COUNT_MAX)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl.
// The memory model answers with a fixed 3-cycle latency. Unwritten words read
// as address ^ 16'hA5A5. The reference model tracks which memory line each
// cache index holds, plus a shadow copy of memory contents.
module tb_data_cache_ctrl;

  localparam int LINES    = 4;
  localparam int WORDS    = 4;
  localparam int MEM_LAT  = 3;
  localparam int OP_STALL = MEM_LAT + 1;
  localparam int MAX_WAIT = 40;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_hit;
    logic [15:0] exp_rdata;
  } vec_t;

  logic                Clk       = 1'b0;
  logic                Reset_N   = 1'b0;
  logic                d_readM   = 1'b0;
  logic                d_writeM  = 1'b0;
  logic [15:0]         d_address = '0;
  logic [15:0]         d_wdata   = '0;
  logic [15:0]         d_rdata;
  logic                d_stall;
  logic                m_readM;
  logic                m_writeM;
  logic [15:0]         m_address;
  logic [15:0]         m_wdata;
  logic [16*WORDS-1:0] m_rdata;
  logic                m_ack;
  logic                mem_ack;
  logic                stray_ack = 1'b0;
  logic [15:0]         hit_count;
  logic [15:0]         miss_count;
  int                  mem_cnt;

  int vec_count   = 0;
  int miscompares = 0;

  logic [15:0] mem_w       [0:65535];
  bit          mem_written [0:65535];

  logic [15:0] ref_w       [0:65535];
  bit          ref_written [0:65535];
  bit          res_valid   [LINES];
  int          res_line    [LINES];
  int          exp_hits;
  int          exp_misses;

  data_cache_ctrl #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .d_readM    (d_readM),
    .d_writeM   (d_writeM),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_stall    (d_stall),
    .m_readM    (m_readM),
    .m_writeM   (m_writeM),
    .m_address  (m_address),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 Clk = ~Clk;

  assign m_ack = mem_ack | stray_ack;

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (mem_written[a]) return mem_w[a];
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    if (ref_written[a]) return ref_w[a];
    return a ^ 16'hA5A5;
  endfunction

  // Memory model: counts request cycles, then pulses ack with the line / commits the store
  always @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      mem_ack <= 1'b0;
      mem_cnt <= 0;
      m_rdata <= '0;
    end else begin
      mem_ack <= 1'b0;
      if ((m_readM || m_writeM) && !mem_ack) begin
        if (mem_cnt == MEM_LAT - 1) begin
          mem_ack <= 1'b1;
          mem_cnt <= 0;
          if (m_writeM) begin
            mem_w[m_address]       <= m_wdata;
            mem_written[m_address] <= 1'b1;
          end
          for (int w = 0; w < WORDS; w++) begin
            m_rdata[w*16 +: 16] <= memRead((m_address & 16'hFFFC) | 16'(w));
          end
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end
  end

  // The datapath must never raise load and store together
  always @(posedge Clk) begin
    if (Reset_N) begin
      assert (!(d_readM && d_writeM)) else $error("[TB] illegal simultaneous read and write request");
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic modelAccess(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                             output bit hit, output logic [15:0] rd);
    int line;
    int idx;
    line = int'(a) / WORDS;
    idx  = line % LINES;
    hit  = 1'b0;
    rd   = '0;
    if (wr) begin
      ref_w[a]       = wd;
      ref_written[a] = 1'b1;
    end else begin
      hit = res_valid[idx] && (res_line[idx] == line);
      rd  = refRead(a);
      if (hit) begin
        if (exp_hits < 65535) exp_hits++;
      end else begin
        if (exp_misses < 65535) exp_misses++;
        res_valid[idx] = 1'b1;
        res_line[idx]  = line;
      end
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                               output int stall_cyc, output logic [15:0] rd);
    bit done;
    done      = 1'b0;
    stall_cyc = 0;
    rd        = '0;
    d_readM   = !wr;
    d_writeM  = wr;
    d_address = a;
    d_wdata   = wd;
    for (int c = 0; c < MAX_WAIT && !done; c++) begin
      @(negedge Clk);
      if (c == 0) checkOutput("m_idle", {m_readM, m_writeM}, 2'b00);
      if (c == 1) begin
        checkOutput("m_req", {m_readM, m_writeM}, wr ? 2'b01 : 2'b10);
        checkOutput("m_addr", m_address, wr ? a : (a & 16'hFFFC));
        if (wr) checkOutput("m_wdata", m_wdata, wd);
      end
      if (!d_stall) begin
        done = 1'b1;
        rd   = d_rdata;
      end else begin
        stall_cyc++;
      end
      @(posedge Clk);
      #1;
    end
    if (!done) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL timeout: d_stall still 1 after %0d cycles, required 0", MAX_WAIT);
    end
    d_readM  = 1'b0;
    d_writeM = 1'b0;
  endtask

  task automatic runOp(input string name, input bit wr, input logic [15:0] a,
                       input logic [15:0] wd, input bit exp_hit, input logic [15:0] exp_rd);
    int          sc;
    logic [15:0] rd;
    applyStimulus(wr, a, wd, sc, rd);
    checkOutput({name, ".stall"}, sc, (!wr && exp_hit) ? 0 : OP_STALL);
    if (!wr) checkOutput({name, ".rdata"}, rd, exp_rd);
    checkOutput({name, ".hits"}, hit_count, exp_hits);
    checkOutput({name, ".misses"}, miss_count, exp_misses);
  endtask

  task automatic idleCycle();
    @(negedge Clk);
    checkOutput("idle.stall", d_stall, 1'b0);
    checkOutput("idle.rdata", d_rdata, 16'h0000);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl [14];
    bit          m_hit;
    logic [15:0] m_rd;
    bit          r_wr;
    logic [15:0] r_a;
    logic [15:0] r_wd;
    int          gap;

    tbl[0]  = '{1'b0, 16'h0012, 16'h0000, 1'b0, 16'hA5B7};
    tbl[1]  = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'hA5B6};
    tbl[2]  = '{1'b1, 16'h0013, 16'h1234, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'h1234};
    tbl[4]  = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0040, 16'h0000, 1'b0, 16'hBEEF};
    tbl[6]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hA5B5};
    tbl[7]  = '{1'b0, 16'h0050, 16'h0000, 1'b0, 16'hA5F5};
    tbl[8]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hA5B5};
    tbl[9]  = '{1'b0, 16'h0011, 16'h0000, 1'b1, 16'hA5B4};
    tbl[10] = '{1'b1, 16'h0080, 16'h5555, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'h1234};
    tbl[12] = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'hA5A1};
    tbl[13] = '{1'b0, 16'h0007, 16'h0000, 1'b1, 16'hA5A2};

    modelReset();
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst.stall", d_stall, 1'b0);
    checkOutput("rst.rdata", d_rdata, 16'h0000);
    checkOutput("rst.m_req", {m_readM, m_writeM}, 2'b00);
    checkOutput("rst.m_addr", m_address, 16'h0000);
    checkOutput("rst.m_wdata", m_wdata, 16'h0000);
    checkOutput("rst.hits", hit_count, 16'h0000);
    checkOutput("rst.misses", miss_count, 16'h0000);
    Reset_N = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      modelAccess(tbl[i].wr, tbl[i].addr, tbl[i].wdata, m_hit, m_rd);
      runOp($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_hit, tbl[i].exp_rdata);
    end
    idleCycle();

    d_readM   = 1'b1;
    d_address = 16'h0052;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Reset_N = 1'b0;
    #1;
    checkOutput("midrst.m_req", {m_readM, m_writeM}, 2'b00);
    checkOutput("midrst.m_addr", m_address, 16'h0000);
    checkOutput("midrst.hits", hit_count, 16'h0000);
    checkOutput("midrst.misses", miss_count, 16'h0000);
    d_readM = 1'b0;
    modelReset();
    @(posedge Clk);
    #1;
    Reset_N = 1'b1;
    @(posedge Clk);
    #1;
    stray_ack = 1'b1;
    @(negedge Clk);
    checkOutput("stray.stall", d_stall, 1'b0);
    @(posedge Clk);
    #1;
    stray_ack = 1'b0;
    checkOutput("stray.m_req", {m_readM, m_writeM}, 2'b00);
    checkOutput("stray.misses", miss_count, 16'h0000);
    modelAccess(1'b0, 16'h0012, 16'h0000, m_hit, m_rd);
    runOp("postrst", 1'b0, 16'h0012, 16'h0000, 1'b0, 16'hA5B7);

    for (int i = 0; i < 150; i++) begin
      r_wr = ($urandom_range(0, 9) < 3);
      r_a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 47));
      r_wd = 16'($urandom);
      modelAccess(r_wr, r_a, r_wd, m_hit, m_rd);
      runOp($sformatf("rnd%0d", i), r_wr, r_a, r_wd, m_hit, m_rd);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idleCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
